// File: rtl/guitar_effect_host_if.sv
// Avalon-MM bus between guitar_effect_host (master) and the guitar_effect peripheral (slave).
interface guitar_effect_host_if;
  logic [4:0]  avl_address;
  logic        avl_write;
  logic        avl_read;
  logic [31:0] avl_writedata;
  logic [31:0] avl_readdata;

  modport master (output avl_address, avl_write, avl_read, avl_writedata,
                  input  avl_readdata);
  modport slave  (input  avl_address, avl_write, avl_read, avl_writedata,
                  output avl_readdata);
endinterface

// File: rtl/guitar_effect_host.sv
// Avalon-MM master for the guitar_effect peripheral: streams samples in/out, loads the
// distortion gain/boost and checks the status word after every data transfer.
module guitar_effect_host #(
  parameter int READ_LATENCY = 2,
  parameter int POLL_DIV     = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          cfg_gain,
  input  logic [31:0]          cfg_boost,
  input  logic                 cfg_load,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  guitar_effect_host_if.master avl,
  output logic                 err_overflow,
  output logic                 err_underflow,
  input  logic                 err_clear,
  output logic [15:0]          drop_cnt
);
  localparam logic [4:0] ADDR_GAIN   = 5'd1;
  localparam logic [4:0] ADDR_BOOST  = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_DATA   = 5'd5;
  localparam int STAGES = READ_LATENCY + 1;
  localparam int PW     = $clog2(POLL_DIV + 1);
  localparam int RW     = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    IDLE, CFG_G, CFG_B, WR, WST, WWAIT, RD, RWAIT, RST, RSWAIT
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     in_buf, gain_q, boost_q, rdata_q, tmp_q;
  logic            in_full, cfg_pend;
  logic [PW-1:0]   poll_q;
  logic [RW-1:0]   retry_q;
  logic [STAGES:1] vld_pipe;

  logic            st_rdy, retry_ok;
  logic            wr_d, rd_d;
  logic [4:0]      addr_d;
  logic [31:0]     wdata_d;
  logic            in_free, drop, retry_inc, tmp_ld, out_ld, under;

  // vld_pipe[READ_LATENCY] marks the readdata cycle; one stage later the captured word is usable.
  assign st_rdy   = vld_pipe[STAGES];
  assign retry_ok = retry_q < RW'(MAX_RETRY);
  assign in_ready = ~in_full;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_pend)                       state_d = CFG_G;
        else if (in_full)                   state_d = WR;
        else if (!out_valid && poll_q == '0) state_d = RD;
      end
      CFG_G:  state_d = CFG_B;
      CFG_B:  state_d = IDLE;
      WR:     state_d = WST;
      WST:    state_d = WWAIT;
      WWAIT:  if (st_rdy) state_d = (rdata_q[4] && retry_ok) ? WR : IDLE;
      RD:     state_d = RWAIT;
      RWAIT:  if (st_rdy) state_d = RST;
      RST:    state_d = RSWAIT;
      RSWAIT: if (st_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state so the registered avl_* line up with the state.
  always_comb begin
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    in_free   = 1'b0;
    drop      = 1'b0;
    retry_inc = 1'b0;
    tmp_ld    = 1'b0;
    out_ld    = 1'b0;
    under     = 1'b0;
    case (state_d)
      CFG_G: begin wr_d = 1'b1; addr_d = ADDR_GAIN;   wdata_d = gain_q;  end
      CFG_B: begin wr_d = 1'b1; addr_d = ADDR_BOOST;  wdata_d = boost_q; end
      WR:    begin wr_d = 1'b1; addr_d = ADDR_DATA;   wdata_d = in_buf;  end
      WST:   begin rd_d = 1'b1; addr_d = ADDR_STATUS; end
      RD:    begin rd_d = 1'b1; addr_d = ADDR_DATA;   end
      RST:   begin rd_d = 1'b1; addr_d = ADDR_STATUS; end
      default: ;
    endcase
    if (st_rdy) begin
      case (state_q)
        WWAIT: begin
          if (!rdata_q[4])   in_free = 1'b1;
          else if (retry_ok) retry_inc = 1'b1;
          else begin
            in_free = 1'b1;
            drop    = 1'b1;
          end
        end
        RWAIT:  tmp_ld = 1'b1;
        RSWAIT: begin
          if (!rdata_q[3]) out_ld = 1'b1;
          else             under  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avl.avl_write     <= 1'b0;
      avl.avl_read      <= 1'b0;
      avl.avl_address   <= '0;
      avl.avl_writedata <= '0;
      vld_pipe          <= '0;
      rdata_q           <= '0;
      tmp_q             <= '0;
      in_buf            <= '0;
      in_full           <= 1'b0;
      gain_q            <= '0;
      boost_q           <= '0;
      cfg_pend          <= 1'b0;
      poll_q            <= PW'(POLL_DIV);
      retry_q           <= '0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      err_overflow      <= 1'b0;
      err_underflow     <= 1'b0;
      drop_cnt          <= '0;
    end else begin
      avl.avl_write     <= wr_d;
      avl.avl_read      <= rd_d;
      avl.avl_address   <= addr_d;
      avl.avl_writedata <= wdata_d;
      vld_pipe          <= {vld_pipe[STAGES-1:1], avl.avl_read};
      if (vld_pipe[READ_LATENCY]) rdata_q <= avl.avl_readdata;
      if (tmp_ld) tmp_q <= rdata_q;

      // A late cfg_load only re-arms: write data was already registered at issue.
      if (cfg_load) begin
        gain_q   <= cfg_gain;
        boost_q  <= cfg_boost;
        cfg_pend <= 1'b1;
      end else if (state_d == CFG_G) begin
        cfg_pend <= 1'b0;
      end

      if (state_d == RD)     poll_q <= PW'(POLL_DIV);
      else if (poll_q != '0) poll_q <= poll_q - 1'b1;

      if (in_free) in_full <= 1'b0;
      if (in_valid && in_ready) begin
        in_buf  <= in_data;
        in_full <= 1'b1;
      end

      if (in_free)        retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + 1'b1;

      if (out_ld) begin
        out_data  <= tmp_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      err_overflow  <= drop  | (err_overflow  & ~err_clear);
      err_underflow <= under | (err_underflow & ~err_clear);
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule
